reg_bank_scan: RTL and testbench

Register bank of DEPTH x WIDTH entries that pairs a write port with the read side of the processor's register interface. It has two synchronous read ports for the datapath and a scan-out sequencer that streams every entry over a valid/ready handshake for debug and bench checking. It sits beside the processor register storage and consumes the same wen/in style write stream.

---
 rtl/reg_pkg.sv | 13 +
 rtl/reg_bank_mem.sv | 51 +++++
 rtl/reg_bank_scan.sv | 110 +++++++++++
 tb/tb_reg_bank_scan.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared defaults and the scan-out FSM state type for the register bank.
package reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_bank_mem.sv
// Storage array with one write port, two registered read ports and one
// combinational scan port; all read paths forward a same-cycle write.
module reg_bank_mem
  import reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wen_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o,
  input  logic [AW-1:0]    saddr_i,
  output logic [WIDTH-1:0] sdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;

  always_comb begin
    rdata_a_d = mem_q[raddr_a_i];
    rdata_b_d = mem_q[raddr_b_i];
    sdata_o   = mem_q[saddr_i];
    if (wen_i && (waddr_i == raddr_a_i)) rdata_a_d = wdata_i;
    if (wen_i && (waddr_i == raddr_b_i)) rdata_b_d = wdata_i;
    if (wen_i && (waddr_i == saddr_i))   sdata_o   = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (wen_i) mem_q[waddr_i] <= wdata_i;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/reg_bank_scan.sv
// Register bank with two registered read ports and a scan-out sequencer that
// streams every entry, in index order, over a valid/ready handshake.
module reg_bank_scan
  import reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  input  logic             dump_start,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_done,
  output logic             busy,
  output dump_state_e      dbg_state
);

  // Handshake: a beat transfers on a posedge where dump_valid && dump_ready.
  // While valid is high and ready low, addr/data are held; data is the value
  // captured when the beat was first presented. ready is ignored when !valid.

  dump_state_e      state_q, state_d;
  logic             valid_q, valid_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    scan_addr;
  logic [WIDTH-1:0] scan_data;

  reg_bank_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wen_i     (wen),
    .waddr_i   (waddr),
    .wdata_i   (in),
    .raddr_a_i (raddr_a),
    .raddr_b_i (raddr_b),
    .rdata_a_o (out_a),
    .rdata_b_o (out_b),
    .saddr_i   (scan_addr),
    .sdata_o   (scan_data)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    scan_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = DUMP;
          valid_d = 1'b1;
          addr_d  = '0;
          data_d  = scan_data;
        end
      end
      DUMP: begin
        if (valid_q && dump_ready) begin
          if (addr_q == AW'(DEPTH - 1)) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else begin
            scan_addr = addr_q + AW'(1);
            addr_d    = scan_addr;
            data_d    = scan_data;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_done  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_reg_bank_scan.sv
// Self-checking bench for reg_bank_scan: read/write/forwarding checks and
// scan-out runs with backpressure, mid-dump writes and mid-dump reset.
module tb_reg_bank_scan;
  import reg_pkg::*;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wen, dump_start, dump_ready;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [W-1:0]  in;
  logic [W-1:0]  out_a, out_b, dump_data;
  logic [AW-1:0] dump_addr;
  logic          dump_valid, dump_done, busy;
  dump_state_e   dbg_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]    model [D];
  logic [W-1:0]    exp_q[$];
  logic [AW+W-1:0] beat_q[$];

  reg_bank_scan #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .in         (in),
    .raddr_a    (raddr_a),
    .raddr_b    (raddr_b),
    .out_a      (out_a),
    .out_b      (out_b),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    wen = 1'b1; waddr = a; in = d;
    tick();
    wen = 1'b0;
    model[a] = d;
  endtask

  task automatic pop_rd(input string tag, input logic [W-1:0] got);
    if (exp_q.size() == 0) chk({tag, "_underflow"}, 32'd0, 32'd1);
    else chk(tag, got, exp_q.pop_front());
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
    raddr_a = a; raddr_b = b;
    exp_q.push_back(model[a]);
    exp_q.push_back(model[b]);
    tick();
    pop_rd("rd_a", out_a);
    pop_rd("rd_b", out_b);
  endtask

  // scen 0: plain dump, 1: writes and stray start mid-dump, 2: reset at beat 5
  task automatic run_dump(input int scen);
    int beats = 0;
    int dones = 0;
    bit stalled = 1'b0;
    bit ready_ph = 1'b0;
    bit aborted = 1'b0;
    bit ended = 1'b0;
    logic [AW-1:0]   hold_a;
    logic [W-1:0]    hold_d;
    logic [AW+W-1:0] e;
    hold_a = '0; hold_d = '0;
    beat_q.delete();
    for (int i = 0; i < D; i++)
      beat_q.push_back({AW'(i), (scen == 1 && i == 9) ? 8'hBB : model[i]});
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    chk("busy_start", {31'd0, busy}, 32'd1);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (!busy) begin ended = 1'b1; break; end
      wen = 1'b0; dump_start = 1'b0;
      if (dump_done) begin
        dones++;
        chk("done_valid_low", {31'd0, dump_valid}, 32'd0);
      end
      if (scen == 2 && dump_valid && dump_addr == 4'd5) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        aborted = 1'b1;
        chk("abort_valid", {31'd0, dump_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, dump_done}, 32'd0);
        chk("abort_addr", {28'd0, dump_addr}, 32'd0);
        for (int i = 0; i < D; i++) model[i] = '0;
        ended = 1'b1;
        break;
      end
      if (dump_valid) begin
        if (stalled) begin
          chk("stall_addr", {28'd0, dump_addr}, {28'd0, hold_a});
          chk("stall_data", {24'd0, dump_data}, {24'd0, hold_d});
        end
        ready_ph = !ready_ph;
        dump_ready = ready_ph;
        if (scen == 1 && dump_addr == 4'd3) begin
          wen = 1'b1;
          waddr = dump_ready ? 4'd9 : 4'd3;
          in = dump_ready ? 8'hBB : 8'hAA;
          model[waddr] = in;
        end
        if (scen == 1 && dump_addr == 4'd6) dump_start = 1'b1;
        if (dump_ready) begin
          if (beat_q.size() == 0) chk("beat_underflow", 32'd0, 32'd1);
          else begin
            e = beat_q.pop_front();
            chk("beat_addr", {28'd0, dump_addr}, {28'd0, e[AW+W-1:W]});
            chk("beat_data", {24'd0, dump_data}, {24'd0, e[W-1:0]});
          end
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_a = dump_addr;
          hold_d = dump_data;
        end
      end else begin
        dump_ready = 1'($urandom_range(0, 1));
      end
      tick();
    end
    wen = 1'b0; dump_start = 1'b0;
    chk("dump_timeout", {31'd0, ended}, 32'd1);
    if (aborted) begin
      chk("abort_no_done", dones, 32'd0);
    end else begin
      chk("beat_count", beats, D);
      chk("done_pulses", dones, 32'd1);
      chk("done_cleared", {31'd0, dump_done}, 32'd0);
      chk("beats_left", beat_q.size(), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_after", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; wen = 1'b1; in = 8'hFF; waddr = 4'd3;
    raddr_a = '0; raddr_b = '0; dump_start = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < D; i++) model[i] = '0;
    tick();
    tick();
    chk("rst_out_a", {24'd0, out_a}, 32'd0);
    chk("rst_out_b", {24'd0, out_b}, 32'd0);
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_addr", {28'd0, dump_addr}, 32'd0);
    chk("rst_data", {24'd0, dump_data}, 32'd0);
    chk("rst_done", {31'd0, dump_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst = 1'b1; wen = 1'b0;
    do_read(4'd3, 4'd3);

    do_write(4'd2, 8'h5C);
    do_read(4'd2, 4'd0);
    wen = 1'b0; waddr = 4'd2; in = 8'h0A;
    tick();
    do_read(4'd2, 4'd2);

    wen = 1'b1; waddr = 4'd7; in = 8'h0A; raddr_a = 4'd7; raddr_b = 4'd7;
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0A);
    tick();
    wen = 1'b0;
    model[7] = 8'h0A;
    pop_rd("fwd_a", out_a);
    pop_rd("fwd_b", out_b);

    for (int i = 0; i < 8; i++) begin
      do_write(4'($urandom_range(0, D - 1)), 8'($urandom_range(0, 255)));
      do_read(4'($urandom_range(0, D - 1)), 4'($urandom_range(0, D - 1)));
    end

    for (int i = 0; i < D; i++) do_write(4'(i), 8'(i + 8'h10));
    run_dump(0);
    run_dump(1);
    do_read(4'd3, 4'd9);
    run_dump(2);
    do_read(4'd1, 4'd15);
    run_dump(0);

    chk("rd_left", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
